dw_sumsq_acc: RTL
=================

// Module: DW_sumsq_acc
// PURPOSE
//   Sequential sum-of-squares accumulator that produces the radicand for the downstream
//   DW_sqrt_func square-root stage (RMS/magnitude path). It accepts a stream of samples over
//   a valid/ready handshake. It squares and sums each block of num_samples samples, then
//   presents the block sum on a held valid/ready output. Downstream, sqrt(radicand) gives
//   the block L2 norm.
// PARAMETERS
//   data_width     8   sample width in bits, >= 2
//   num_samples    16  samples per block, >= 2
//   tc_mode        1   1: samples are two's complement; 0: samples are unsigned
//   radicand_width (localparam) = 2*data_width + clog2(num_samples); never overflows
// PORTS
//   clk       in   1               clock, rising edge
//   rst       in   1               asynchronous active-high reset
//   clr       in   1               synchronous clear; discards the block in progress
//   in_valid  in   1               in_data is valid
//   in_ready  out  1               block can accept a sample
//   in_data   in   data_width      sample
//   out_valid out  1               radicand holds a completed block sum
//   out_ready in   1               downstream takes radicand
//   radicand  out  radicand_width  block sum of squares, unsigned
//   count     out  clog2(num_samples+1)  samples accepted in the current block
// BEHAVIOUR
//   - Reset (async, rst=1):
//     - state=ACC, acc=0, count=0, out_valid=0, radicand=0.
//     - Takes effect immediately, including mid-block or during HOLD.
//   - States:
//     - ACC: in_ready=1, out_valid=0.
//     - HOLD: in_ready=0, out_valid=1.
//   - Accept: a sample is accepted on a cycle where in_valid & in_ready. Otherwise acc and
//     count hold, so gaps in in_valid are harmless.
//   - Square:
//     - tc_mode=1: sq = in_data*in_data, signed; result is non-negative. (-2^(dw-1))^2 = 2^(2dw-2).
//     - tc_mode=0: unsigned product.
//     - sq is zero-extended to radicand_width before adding.
//   - ACC, accept with count < num_samples-1: acc <= acc+sq, count <= count+1.
//   - ACC, accept with count == num_samples-1:
//     - radicand <= acc+sq; out_valid goes 1 the next cycle.
//     - acc <= 0, count <= 0; state goes to HOLD.
//     - Latency: last sample accepted at edge t, out_valid=1 after edge t.
//   - HOLD:
//     - radicand stays stable while out_valid & !out_ready.
//     - in_valid is ignored; no sample is accepted.
//   - HOLD, out_ready=1: out_valid <= 0 and state goes to ACC. in_ready rises the cycle
//     after the handshake. radicand keeps its last value until overwritten.
//   - clr:
//     - Has priority over accept and output handshake.
//     - Next edge: acc=0, count=0, out_valid=0, state=ACC.
//     - A pending (unconsumed) result is dropped.
//   - in_ready and out_valid are decoded from state registers only (no combinational path
//     from in_valid/out_ready).
//   - No wrap-around is possible: count saturates by design at num_samples-1 before the
//     block closes.
// TESTING  (data_width=8, num_samples=4 unless stated; radicand_width=18)
//   1. tc_mode=1, samples 3,-4,0,12 back-to-back, out_ready=1 -> out_valid one cycle after
//      4th accept, radicand=169. DW_sqrt_func tc root=13. in_ready low exactly 1 cycle.
//   2. Extremes:
//      - tc_mode=1, four samples -128 -> radicand=65536.
//      - tc_mode=0, four samples 255 -> radicand=260100 (no overflow).
//   3. Backpressure: after test 1 result, out_ready=0 for 5 cycles while in_valid=1 with
//      data 7 -> radicand stays 169, in_ready=0, count=0.
//      Then out_ready=1 for 1 cycle -> next block sums only post-handshake samples.
//   4. Gaps and clr:
//      - samples 1,2 with idle cycles between -> count=2.
//      - clr=1 -> count=0.
//      - then 5,5,5,5 -> radicand=100.
//      - clr asserted in HOLD -> out_valid=0 next cycle.
//   5. Async reset: assert rst mid-block (count=3) and again in HOLD -> out_valid=0,
//      count=0, radicand=0 without waiting for a clk edge. First block after release is
//      correct.
//   6. Random: 10k samples with random in_valid/out_ready gaps, tc_mode 0 and 1 -> every
//      radicand matches the model sum, and no sample is lost or duplicated.

Source files
------------

// File: rtl/dw_sumsq_acc.sv
// Block sum-of-squares accumulator: squares each accepted sample and presents the
// sum of every num_samples samples as a held radicand for a downstream square root.
module dw_sumsq_acc #(
  parameter int data_width  = 8,
  parameter int num_samples = 16,
  parameter int tc_mode     = 1,
  localparam int radicand_width = 2 * data_width + $clog2(num_samples),
  localparam int count_width    = $clog2(num_samples + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_width-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [radicand_width-1:0] radicand,
  output logic [count_width-1:0]    count
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready/out_valid depend only on state_q, never on in_valid/out_ready.
  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam int sq_width = 2 * data_width;
  localparam bit tc       = (tc_mode != 0);

  state_t                    state_q, state_d;
  logic [radicand_width-1:0] acc_q, acc_d;
  logic [radicand_width-1:0] rad_q, rad_d;
  logic [count_width-1:0]    count_q, count_d;

  logic                      sign_bit;
  logic [sq_width-1:0]       data_ext;
  logic [sq_width-1:0]       sq;
  logic [radicand_width-1:0] sq_ext;
  logic                      last_sample;

  // Low 2*dw bits of the extended product equal the exact square, which always fits.
  assign sign_bit    = tc ? in_data[data_width-1] : 1'b0;
  assign data_ext    = {{data_width{sign_bit}}, in_data};
  assign sq          = data_ext * data_ext;
  assign sq_ext      = {{(radicand_width - sq_width){1'b0}}, sq};
  assign last_sample = (count_q == count_width'(num_samples - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rad_d   = rad_q;
    count_d = count_q;
    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (last_sample) begin
              rad_d   = acc_q + sq_ext;
              acc_d   = '0;
              count_d = '0;
              state_d = ST_HOLD;
            end else begin
              acc_d   = acc_q + sq_ext;
              count_d = count_q + count_width'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      rad_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rad_q   <= rad_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign radicand  = rad_q;
  assign count     = count_q;

endmodule
